// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg -- shared core types for the load/store unit.
//   lsu_size_e  : access size encoding presented by decode.
//   lsu_state_e : LSU control FSM states.
//   norm_size   : folds the unused size code 3 onto LSU_WORD.
//   is_misaligned : natural-alignment test used when LSU_MISALIGN_ERR_EN is set.
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    function automatic lsu_size_e norm_size(input logic [1:0] size);
        case (size)
            2'd0:    return LSU_BYTE;
            2'd1:    return LSU_HALF;
            default: return LSU_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            LSU_HALF: return addr_lo[0];
            LSU_WORD: return (addr_lo != 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if -- word-oriented data memory bus between the LSU and memory.
//   data_req_op    : request valid (held until data_gnt_ip)
//   data_we_op     : 1 = write
//   data_addr_op   : word-aligned address
//   data_be_op     : byte enables
//   data_wdata_op  : lane-placed write data
//   data_gnt_ip    : memory accepted the request
//   data_rvalid_ip : response valid
//   data_rdata_ip  : read data (full word)
// Modports: master = LSU side, slave = memory side.
// -----------------------------------------------------------------------------
interface lsu_if;
    logic        data_req_op;
    logic        data_we_op;
    logic [31:0] data_addr_op;
    logic [3:0]  data_be_op;
    logic [31:0] data_wdata_op;
    logic        data_gnt_ip;
    logic        data_rvalid_ip;
    logic [31:0] data_rdata_ip;

    modport master (
        output data_req_op, data_we_op, data_addr_op, data_be_op, data_wdata_op,
        input  data_gnt_ip, data_rvalid_ip, data_rdata_ip
    );

    modport slave (
        input  data_req_op, data_we_op, data_addr_op, data_be_op, data_wdata_op,
        output data_gnt_ip, data_rvalid_ip, data_rdata_ip
    );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align -- combinational lane steering for the LSU.
//   size, addr_lo   : access size and low address bits
//   sign_ext        : sign-extend narrow loads
//   wdata           : store data from the register file
//   rdata           : raw word from memory
//   be              : byte enables
//   wdata_lane      : store data replicated across lanes
//   rdata_ext       : load data shifted to bit 0, masked and extended
// -----------------------------------------------------------------------------
module lsu_align
    import core_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    function automatic logic [31:0] extend_load(input lsu_size_e sz, input logic sx,
                                                input logic [31:0] val);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = val[7:0];
        h = val[15:0];
        case (sz)
            LSU_BYTE: return sx ? 32'(b) : {24'd0, val[7:0]};
            LSU_HALF: return sx ? 32'(h) : {16'd0, val[15:0]};
            default:  return val;
        endcase
    endfunction

    // HALF ignores addr[0] and WORD ignores addr[1:0]; only the natural lane is used.
    always_comb begin
        lane       = 2'd0;
        be         = 4'b1111;
        wdata_lane = wdata;
        case (size)
            LSU_BYTE: begin
                lane       = addr_lo;
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            LSU_HALF: begin
                lane       = {addr_lo[1], 1'b0};
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted   = rdata >> {lane, 3'b000};
    assign rdata_ext = extend_load(size, sign_ext, shifted);

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit: accepts one request from decode, issues it on the
// data bus, waits for the response (bounded by TIMEOUT_CYCLES) and returns a
// one-cycle completion pulse with aligned/extended load data and an error flag.
//
// Parameters : TIMEOUT_CYCLES (default 16) max WAIT cycles before abort.
// Ports      : clk, reset (sync, active-high)
//              lsu_enable_ip, lsu_we_ip, lsu_size_ip, lsu_sign_ext_ip,
//              lsu_addr_ip, lsu_addr_valid_ip, lsu_wdata_ip   (request)
//              lsu_ready_op, lsu_valid_op, lsu_rdata_op, lsu_err_op (response)
//              bus : lsu_if.master (data memory bus)
// Option     : define LSU_MISALIGN_ERR_EN to fail misaligned HALF/WORD accesses
//              immediately without touching the bus.
// -----------------------------------------------------------------------------
module lsu
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_enable_ip,
    input  logic        lsu_we_ip,
    input  logic [1:0]  lsu_size_ip,
    input  logic        lsu_sign_ext_ip,
    input  logic [31:0] lsu_addr_ip,
    input  logic        lsu_addr_valid_ip,
    input  logic [31:0] lsu_wdata_ip,
    output logic        lsu_ready_op,
    output logic        lsu_valid_op,
    output logic [31:0] lsu_rdata_op,
    output logic        lsu_err_op,
    lsu_if.master       bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [31:0] addr_p0;
    logic        we_p0;
    lsu_size_e   size_p0;
    logic        sext_p0;
    logic [31:0] wdata_p0;

    logic [31:0] rdata_p1;
    logic        err_p1;

    logic        accept;
    logic        misalign_now;
    logic        res_load;
    logic [31:0] res_rdata_d;
    logic        res_err_d;

    logic [3:0]  be_w;
    logic [31:0] wdata_lane_w;
    logic [31:0] rdata_ext_w;

    assign accept = (state_q == LSU_IDLE) && lsu_enable_ip && lsu_addr_valid_ip;

`ifdef LSU_MISALIGN_ERR_EN
    assign misalign_now = is_misaligned(norm_size(lsu_size_ip), lsu_addr_ip[1:0]);
`else
    assign misalign_now = 1'b0;
`endif

    lsu_align u_align (
        .size       (size_p0),
        .sign_ext   (sext_p0),
        .addr_lo    (addr_p0[1:0]),
        .wdata      (wdata_p0),
        .rdata      (bus.data_rdata_ip),
        .be         (be_w),
        .wdata_lane (wdata_lane_w),
        .rdata_ext  (rdata_ext_w)
    );

    // ---- control state: FSM and WAIT-cycle counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LSU_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ---- next state, result selection and bus/response outputs ----
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        res_load    = 1'b0;
        res_rdata_d = 32'd0;
        res_err_d   = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    // Result is cleared here; a misaligned access completes with it as-is.
                    res_load  = 1'b1;
                    res_err_d = misalign_now;
                    state_d   = misalign_now ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (bus.data_gnt_ip) begin
                    state_d    = LSU_WAIT;
                    wait_cnt_d = '0;
                end
            end
            LSU_WAIT: begin
                // A response on the final counted cycle still wins over the timeout.
                if (bus.data_rvalid_ip) begin
                    res_load    = 1'b1;
                    res_rdata_d = we_p0 ? 32'd0 : rdata_ext_w;
                    state_d     = LSU_DONE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    res_load  = 1'b1;
                    res_err_d = 1'b1;
                    state_d   = LSU_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = LSU_IDLE;
        endcase

        lsu_ready_op      = (state_q == LSU_IDLE);
        lsu_valid_op      = (state_q == LSU_DONE);
        lsu_rdata_op      = lsu_valid_op ? rdata_p1 : 32'd0;
        lsu_err_op        = lsu_valid_op & err_p1;

        bus.data_req_op   = (state_q == LSU_REQ);
        bus.data_we_op    = bus.data_req_op & we_p0;
        bus.data_addr_op  = bus.data_req_op ? {addr_p0[31:2], 2'b00} : 32'd0;
        bus.data_be_op    = bus.data_req_op ? be_w : 4'b0000;
        bus.data_wdata_op = bus.data_req_op ? wdata_lane_w : 32'd0;
    end

    // ---- request capture (p0) and completion result (p1); datapath, no reset ----
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= lsu_addr_ip;
            we_p0    <= lsu_we_ip;
            size_p0  <= norm_size(lsu_size_ip);
            sext_p0  <= lsu_sign_ext_ip;
            wdata_p0 <= lsu_wdata_ip;
        end
        if (res_load) begin
            rdata_p1 <= res_rdata_d;
            err_p1   <= res_err_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_enable_ip;
    logic        lsu_we_ip;
    logic [1:0]  lsu_size_ip;
    logic        lsu_sign_ext_ip;
    logic [31:0] lsu_addr_ip;
    logic        lsu_addr_valid_ip;
    logic [31:0] lsu_wdata_ip;
    logic        lsu_ready_op;
    logic        lsu_valid_op;
    logic [31:0] lsu_rdata_op;
    logic        lsu_err_op;

    lsu_if bus ();

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .lsu_enable_ip     (lsu_enable_ip),
        .lsu_we_ip         (lsu_we_ip),
        .lsu_size_ip       (lsu_size_ip),
        .lsu_sign_ext_ip   (lsu_sign_ext_ip),
        .lsu_addr_ip       (lsu_addr_ip),
        .lsu_addr_valid_ip (lsu_addr_valid_ip),
        .lsu_wdata_ip      (lsu_wdata_ip),
        .lsu_ready_op      (lsu_ready_op),
        .lsu_valid_op      (lsu_valid_op),
        .lsu_rdata_op      (lsu_rdata_op),
        .lsu_err_op        (lsu_err_op),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int nbytes(input int sz);
        if (sz == 0) return 1;
        if (sz == 1) return 2;
        return 4;
    endfunction

    function automatic int lane_of(input int sz, input logic [31:0] a);
        if (sz == 0) return int'(a % 4);
        if (sz == 1) return int'((a % 4) / 2) * 2;
        return 0;
    endfunction

    function automatic logic [3:0] model_be(input int sz, input logic [31:0] a);
        int t;
        t = ((1 << nbytes(sz)) - 1) << lane_of(sz, a);
        return t[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] w);
        int n;
        logic [63:0] m;
        logic [31:0] unit;
        logic [31:0] res;
        n    = nbytes(sz);
        m    = (64'd1 << (8 * n)) - 64'd1;
        unit = w & m[31:0];
        res  = 32'd0;
        for (int k = 0; k < 4 / n; k++) res = res | (unit << (8 * n * k));
        return res;
    endfunction

    function automatic logic [31:0] model_load(input int sz, input logic se,
                                               input logic [31:0] a, input logic [31:0] r);
        int n;
        int ln;
        logic [63:0] m;
        logic [63:0] v;
        n  = nbytes(sz);
        ln = lane_of(sz, a);
        m  = (64'd1 << (8 * n)) - 64'd1;
        v  = ({32'd0, r} >> (8 * ln)) & m;
        if (se && n < 4 && v[8 * n - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic model_misaligned(input int sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_ERR_EN
        int n;
        n = nbytes(sz);
        return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
`else
        return (sz < 0) && (a == 32'd0);
`endif
    endfunction

    task automatic wait_ready;
        int guard;
        guard = 0;
        while (!lsu_ready_op && guard < 40) begin
            tick;
            guard++;
        end
        check_eq("ready_before_accept", 32'(lsu_ready_op), 32'd1);
    endtask

    // One complete transaction; gd = grant delay in REQ cycles, rvd = response
    // delay in WAIT cycles (rvd >= TO means no response at all).
    task automatic do_txn(input logic w, input logic [1:0] sz_raw, input logic se,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int gd, input int rvd);
        int sz;
        logic mis;
        logic [31:0] exp_r;
        logic exp_e;
        sz    = (sz_raw == 2'd3) ? 2 : int'(sz_raw);
        mis   = model_misaligned(sz, a);
        exp_r = 32'd0;
        exp_e = 1'b0;
        wait_ready();
        lsu_enable_ip     = 1'b1;
        lsu_addr_valid_ip = 1'b1;
        lsu_we_ip         = w;
        lsu_size_ip       = sz_raw;
        lsu_sign_ext_ip   = se;
        lsu_addr_ip       = a;
        lsu_wdata_ip      = wd;
        tick;
        // Scramble the request inputs: the captured copy must be used.
        lsu_enable_ip     = 1'b0;
        lsu_addr_valid_ip = 1'($urandom);
        lsu_we_ip         = 1'($urandom);
        lsu_size_ip       = 2'($urandom);
        lsu_sign_ext_ip   = 1'($urandom);
        lsu_addr_ip       = $urandom;
        lsu_wdata_ip      = $urandom;
        if (mis) begin
            exp_e = 1'b1;
            check_eq("mis_no_req", 32'(bus.data_req_op), 32'd0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                check_eq("req_held", 32'(bus.data_req_op), 32'd1);
                check_eq("req_addr", bus.data_addr_op, {a[31:2], 2'b00});
                check_eq("req_be", 32'(bus.data_be_op), 32'(model_be(sz, a)));
                check_eq("req_we", 32'(bus.data_we_op), 32'(w));
                if (w) check_eq("req_wdata", bus.data_wdata_op, model_wdata(sz, wd));
                check_eq("req_not_ready", 32'(lsu_ready_op), 32'd0);
                check_eq("req_no_valid", 32'(lsu_valid_op), 32'd0);
                bus.data_gnt_ip    = (i == gd);
                bus.data_rvalid_ip = 1'($urandom);
                bus.data_rdata_ip  = $urandom;
                tick;
            end
            bus.data_gnt_ip = 1'b0;
            if (rvd < TO) begin
                for (int j = 0; j <= rvd; j++) begin
                    check_eq("wait_no_req", 32'(bus.data_req_op), 32'd0);
                    check_eq("wait_no_valid", 32'(lsu_valid_op), 32'd0);
                    bus.data_rvalid_ip = (j == rvd);
                    bus.data_rdata_ip  = (j == rvd) ? rd : $urandom;
                    tick;
                end
                exp_r = w ? 32'd0 : model_load(sz, se, a, rd);
            end else begin
                for (int j = 0; j < TO; j++) begin
                    check_eq("to_no_valid", 32'(lsu_valid_op), 32'd0);
                    bus.data_rvalid_ip = 1'b0;
                    tick;
                end
                exp_e = 1'b1;
            end
        end
        check_eq("done_valid", 32'(lsu_valid_op), 32'd1);
        check_eq("done_rdata", lsu_rdata_op, exp_r);
        check_eq("done_err", 32'(lsu_err_op), 32'(exp_e));
        // A response arriving in DONE must be ignored.
        bus.data_rvalid_ip = 1'b1;
        bus.data_rdata_ip  = $urandom;
        tick;
        check_eq("after_no_valid", 32'(lsu_valid_op), 32'd0);
        check_eq("after_ready", 32'(lsu_ready_op), 32'd1);
        check_eq("after_no_req", 32'(bus.data_req_op), 32'd0);
        bus.data_rvalid_ip = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        lsu_enable_ip      = 1'b0;
        lsu_we_ip          = 1'b0;
        lsu_size_ip        = 2'd0;
        lsu_sign_ext_ip    = 1'b0;
        lsu_addr_ip        = 32'd0;
        lsu_addr_valid_ip  = 1'b0;
        lsu_wdata_ip       = 32'd0;
        bus.data_gnt_ip    = 1'b0;
        bus.data_rvalid_ip = 1'b0;
        bus.data_rdata_ip  = 32'd0;
        tick;
        tick;
        reset = 1'b0;

        check_eq("rst_ready", 32'(lsu_ready_op), 32'd1);
        check_eq("rst_valid", 32'(lsu_valid_op), 32'd0);
        check_eq("rst_rdata", lsu_rdata_op, 32'd0);
        check_eq("rst_err", 32'(lsu_err_op), 32'd0);
        check_eq("rst_req", 32'(bus.data_req_op), 32'd0);
        check_eq("rst_we", 32'(bus.data_we_op), 32'd0);
        check_eq("rst_addr", bus.data_addr_op, 32'd0);
        check_eq("rst_be", 32'(bus.data_be_op), 32'd0);
        check_eq("rst_wdata", bus.data_wdata_op, 32'd0);

        // Enable without addr_valid is not a request.
        lsu_enable_ip = 1'b1;
        lsu_addr_ip   = 32'h100;
        tick;
        tick;
        check_eq("noaddrv_ready", 32'(lsu_ready_op), 32'd1);
        check_eq("noaddrv_req", 32'(bus.data_req_op), 32'd0);
        lsu_enable_ip = 1'b0;

        // Directed scenarios.
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
        do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 32'h80123456, 0, 1);
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 32'h80123456, 1, 0);
        do_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'd0, 4, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'h12345678, 0, TO);
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'hCAFEF00D, 2, TO - 1);
        do_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 32'hA5A5A5A5, 0, 0);
        do_txn(1'b0, 2'd1, 1'b1, 32'h1FE, 32'd0, 32'h8001_7FFF, 0, 0);
        do_txn(1'b0, 2'd3, 1'b0, 32'h400, 32'd0, 32'h0BADC0DE, 0, 0);

        // Reset while in WAIT; a late response must not produce a completion.
        wait_ready();
        lsu_enable_ip     = 1'b1;
        lsu_addr_valid_ip = 1'b1;
        lsu_we_ip         = 1'b0;
        lsu_size_ip       = 2'd2;
        lsu_addr_ip       = 32'h300;
        tick;
        lsu_enable_ip   = 1'b0;
        bus.data_gnt_ip = 1'b1;
        tick;
        bus.data_gnt_ip = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_eq("midrst_ready", 32'(lsu_ready_op), 32'd1);
        check_eq("midrst_valid", 32'(lsu_valid_op), 32'd0);
        check_eq("midrst_req", 32'(bus.data_req_op), 32'd0);
        bus.data_rvalid_ip = 1'b1;
        bus.data_rdata_ip  = 32'h11223344;
        tick;
        bus.data_rvalid_ip = 1'b0;
        check_eq("midrst_late_valid", 32'(lsu_valid_op), 32'd0);
        check_eq("midrst_late_ready", 32'(lsu_ready_op), 32'd1);
        tick;
        check_eq("midrst_late_valid2", 32'(lsu_valid_op), 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            int rvd;
            rvd = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
            do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 4)), rvd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max cycles in WAIT without data_rvalid_ip before abort.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-003 clk  in  1  core clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 lsu_enable_ip  in  1  decode requests a load/store.
REQ-006 lsu_we_ip  in  1  1 = store, 0 = load.
REQ-007 lsu_size_ip  in  2  lsu_size_e: LSU_BYTE=0, LSU_HALF=1, LSU_WORD=2; 3 treated as LSU_WORD.
REQ-008 lsu_sign_ext_ip  in  1  sign-extend load data (LB/LH).
REQ-009 lsu_addr_ip  in  32  effective address, driven by ALU alu_result_op.
REQ-010 lsu_addr_valid_ip  in  1  driven by ALU alu_valid_op.
REQ-011 lsu_wdata_ip  in  32  store data (rs2).
REQ-012 lsu_ready_op  out  1  LSU can accept a request.
REQ-013 lsu_valid_op  out  1  one-cycle completion pulse.
REQ-014 lsu_rdata_op  out  32  aligned, extended load result; valid with lsu_valid_op.
REQ-015 lsu_err_op  out  1  error flag; valid with lsu_valid_op.
REQ-016 data_req_op / data_we_op  out  1 / 1  memory request, write enable.
REQ-017 data_addr_op / data_be_op / data_wdata_op  out  32 / 4 / 32  word address, byte enables, lane-placed data.
REQ-018 data_gnt_ip / data_rvalid_ip / data_rdata_ip  in  1 / 1 / 32  grant, response valid, read data.

Function
REQ-019 SHALL accept a request in a cycle where lsu_ready_op && lsu_enable_ip && lsu_addr_valid_ip; enable without addr_valid SHALL be ignored.
REQ-020 SHALL register addr, we, size, sign_ext, wdata on acceptance; later input changes SHALL have no effect.
REQ-021 SHALL use FSM IDLE -> REQ (on accept) -> WAIT (on data_gnt_ip) -> DONE (on data_rvalid_ip or timeout) -> IDLE; lsu_ready_op = (state==IDLE).
REQ-022 In REQ, data_req_op SHALL be 1 with addr/we/be/wdata held stable until data_gnt_ip; data_req_op SHALL be 0 in all other states.
REQ-023 data_addr_op SHALL be {addr[31:2],2'b00}; data_be_op: BYTE 4'b0001<<addr[1:0], HALF 4'b0011<<{addr[1],1'b0}, WORD 4'b1111.
REQ-024 data_wdata_op SHALL replicate the byte 4x (BYTE), the halfword 2x (HALF), or pass the word (WORD).
REQ-025 Load data SHALL be data_rdata_ip >> (8*lane offset), masked to size, then sign- or zero-extended per sign_ext; stores SHALL return lsu_rdata_op = 0.
REQ-026 data_rvalid_ip SHALL be honoured only in WAIT; it is ignored in IDLE, REQ, DONE.
REQ-027 WAIT SHALL count cycles from 0; reaching TIMEOUT_CYCLES without rvalid SHALL go to DONE with lsu_err_op=1, lsu_rdata_op=0.
REQ-028 DONE SHALL assert lsu_valid_op for exactly one cycle; minimum latency accept->valid = 3 cycles (gnt in the first REQ cycle, rvalid in the first WAIT cycle).

Reset
REQ-029 On reset, state SHALL be IDLE, timeout counter 0, lsu_ready_op=1, all other outputs 0.
REQ-030 Reset mid-transaction SHALL abort: data_req_op=0 and no lsu_valid_op on the next cycle; any late rvalid SHALL be ignored.

Configuration
REQ-031 With LSU_MISALIGN_ERR_EN defined, HALF with addr[0]=1 or WORD with addr[1:0]!=0 SHALL skip REQ/WAIT and go IDLE->DONE with lsu_err_op=1, lsu_rdata_op=0, and no bus request.
REQ-032 Without LSU_MISALIGN_ERR_EN, unused low address bits SHALL be ignored (HALF uses addr[1], WORD uses lane 0) and the access SHALL proceed normally.

Structure
REQ-033 lsu_size_e and lsu_state_e SHALL reside in CORE_PKG.
REQ-034 Byte-enable generation, write replication, and load extraction/extension SHALL be a combinational sub-module lsu_align.

Verification
REQ-035 LW addr 0x100, gnt in the first REQ cycle, rvalid next cycle with rdata 0xDEADBEEF -> lsu_valid_op 3 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-036 LB sign_ext addr 0x103, rdata 0x80123456 -> be 4'b1000, lsu_rdata_op 0xFFFFFF80; LBU -> 0x00000080.
REQ-037 SH addr 0x202, wdata 0x0000ABCD, gnt delayed 4 cycles -> req held 5 cycles stable, addr 0x200, be 4'b1100, wdata 0xABCDABCD.
REQ-038 LW with no rvalid -> valid after 16 WAIT cycles with err 1, rdata 0; a later rvalid is ignored.
REQ-039 LW addr 0x101 -> with macro: err 1, no data_req_op; without: bus addr 0x100, be 4'b1111.
REQ-040 Reset asserted in WAIT, rvalid arriving after reset -> no lsu_valid_op, ready 1 next cycle.
